seg_scan_ctrl: RTL and testbench

Four-digit time-multiplexing scan controller for the board's common-anode 7-segment display. It holds a 4-digit packed BCD value and rotates through the digits at a programmable refresh rate. Each slot drives the active-low anode lines directly and feeds one BCD nibble per slot to the downstream BCD-to-7-segment decoder. New values are double-buffered and committed only at frame boundaries, so a digit never shows a half-updated number.

---
 rtl/seg_scan_ctrl.sv | 82 ++++++++
 tb/tb_seg_scan_ctrl.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/seg_scan_ctrl.sv
// Four-digit common-anode display scanner with frame-synchronous double buffering.
// Each digit slot lasts REFRESH_DIV cycles; a new value is committed only when digit 0 starts.
module seg_scan_ctrl #(
    parameter int REFRESH_DIV = 100000,
    parameter int NUM_DIGITS  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] value_in,
    input  logic        load,
    input  logic        blank_lz,
    output logic [3:0]  bcd,
    output logic [3:0]  an,
    output logic [1:0]  digit_idx,
    output logic        frame_tick
);

    localparam int             CW       = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0]  CNT_MAX  = CW'(REFRESH_DIV - 1);
    localparam logic [1:0]     LAST_IDX = 2'(NUM_DIGITS - 1);

    logic [CW-1:0] cnt;
    logic [1:0]    idx;
    logic [15:0]   shadow;
    logic [15:0]   active;

    logic          tick;
    logic [1:0]    idx_nxt;
    logic [15:0]   active_nxt;
    logic [3:0]    nib;
    logic [3:0]    upper_zero;
    logic [3:0]    bcd_nxt;
    logic [3:0]    an_nxt;

    assign tick      = (cnt == CNT_MAX);
    assign digit_idx = idx;

    // Slot outputs are computed from the post-commit value so digit 0 of a new frame
    // already shows the freshly committed number.
    always_comb begin
        idx_nxt    = idx + 2'd1;
        active_nxt = (idx_nxt == 2'd0) ? shadow : active;
        nib        = active_nxt[4*idx_nxt +: 4];

        upper_zero[3] = (active_nxt[15:12] == 4'd0);
        upper_zero[2] = upper_zero[3] && (active_nxt[11:8] == 4'd0);
        upper_zero[1] = upper_zero[2] && (active_nxt[7:4] == 4'd0);
        upper_zero[0] = 1'b0;

        bcd_nxt = 4'hF;
        an_nxt  = 4'b1111;
        if (!((nib > 4'd9) || (blank_lz && upper_zero[idx_nxt]))) begin
            bcd_nxt = nib;
            an_nxt  = ~(4'b0001 << idx_nxt);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= '0;
            idx        <= LAST_IDX;
            shadow     <= '0;
            active     <= '0;
            bcd        <= 4'hF;
            an         <= 4'b1111;
            frame_tick <= 1'b0;
        end else begin
            cnt        <= tick ? '0 : cnt + 1'b1;
            frame_tick <= 1'b0;
            if (load)
                shadow <= value_in;
            if (tick) begin
                idx        <= idx_nxt;
                active     <= active_nxt;
                bcd        <= bcd_nxt;
                an         <= an_nxt;
                frame_tick <= (idx_nxt == 2'd0);
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with REFRESH_DIV=4: reset, scan order, commit boundary,
// leading-zero blanking, invalid nibbles and mid-frame reset.
module tb_seg_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] value_in;
    logic        load;
    logic        blank_lz;
    logic [3:0]  bcd;
    logic [3:0]  an;
    logic [1:0]  digit_idx;
    logic        frame_tick;

    int total = 0;
    int bad   = 0;

    seg_scan_ctrl #(.REFRESH_DIV(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .value_in   (value_in),
        .load       (load),
        .blank_lz   (blank_lz),
        .bcd        (bcd),
        .an         (an),
        .digit_idx  (digit_idx),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [1:0] e_idx, input logic [3:0] e_an,
                       input logic [3:0] e_bcd, input logic e_ft);
        total++;
        assert (digit_idx === e_idx) else begin
            bad++;
            $error("FAIL %s digit_idx got=%0h exp=%0h", tag, digit_idx, e_idx);
        end
        total++;
        assert (an === e_an) else begin
            bad++;
            $error("FAIL %s an got=%b exp=%b", tag, an, e_an);
        end
        total++;
        assert (bcd === e_bcd) else begin
            bad++;
            $error("FAIL %s bcd got=%h exp=%h", tag, bcd, e_bcd);
        end
        total++;
        assert (frame_tick === e_ft) else begin
            bad++;
            $error("FAIL %s frame_tick got=%b exp=%b", tag, frame_tick, e_ft);
        end
    endtask

    initial begin
        rst = 1'b1; load = 1'b0; value_in = 16'h0; blank_lz = 1'b0;
        cyc(3);
        chk("reset", 2'd3, 4'b1111, 4'hF, 1'b0);
        rst = 1'b0;

        // dark for three edges, digit 0 appears on the fourth
        cyc(1); chk("dark1", 2'd3, 4'b1111, 4'hF, 1'b0);
        cyc(1); chk("dark2", 2'd3, 4'b1111, 4'hF, 1'b0);
        cyc(1); chk("dark3", 2'd3, 4'b1111, 4'hF, 1'b0);
        cyc(1); chk("first_frame", 2'd0, 4'b1110, 4'h0, 1'b1);
        cyc(1); chk("first_ft_low", 2'd0, 4'b1110, 4'h0, 1'b0);

        // load 1234 mid-slot; current frame still shows zeros
        load = 1'b1; value_in = 16'h1234;
        cyc(1); load = 1'b0;
        cyc(2); chk("f0_s1", 2'd1, 4'b1101, 4'h0, 1'b0);
        cyc(4); chk("f0_s2", 2'd2, 4'b1011, 4'h0, 1'b0);
        cyc(4); chk("f0_s3", 2'd3, 4'b0111, 4'h0, 1'b0);
        cyc(4); chk("f1_s0", 2'd0, 4'b1110, 4'h4, 1'b1);
        cyc(1); chk("f1_s0_ftlow", 2'd0, 4'b1110, 4'h4, 1'b0);
        cyc(3); chk("f1_s1", 2'd1, 4'b1101, 4'h3, 1'b0);
        cyc(4); chk("f1_s2", 2'd2, 4'b1011, 4'h2, 1'b0);

        // load 5678 during slot 2: no tearing
        load = 1'b1; value_in = 16'h5678;
        cyc(1); load = 1'b0;
        cyc(2); chk("f1_s2_late", 2'd2, 4'b1011, 4'h2, 1'b0);
        cyc(1); chk("f1_s3", 2'd3, 4'b0111, 4'h1, 1'b0);
        cyc(4); chk("f2_s0", 2'd0, 4'b1110, 4'h8, 1'b1);
        cyc(4); chk("f2_s1", 2'd1, 4'b1101, 4'h7, 1'b0);
        cyc(4); chk("f2_s2", 2'd2, 4'b1011, 4'h6, 1'b0);
        cyc(4); chk("f2_s3", 2'd3, 4'b0111, 4'h5, 1'b0);

        // load 4321 early in slot 3, then 9876 exactly on the commit edge
        load = 1'b1; value_in = 16'h4321;
        cyc(1); load = 1'b0;
        cyc(2); load = 1'b1; value_in = 16'h9876;
        cyc(1); load = 1'b0;
        chk("f3_s0_oldshadow", 2'd0, 4'b1110, 4'h1, 1'b1);
        cyc(4); chk("f3_s1", 2'd1, 4'b1101, 4'h2, 1'b0);
        cyc(4); chk("f3_s2", 2'd2, 4'b1011, 4'h3, 1'b0);
        cyc(4); chk("f3_s3", 2'd3, 4'b0111, 4'h4, 1'b0);
        cyc(4); chk("f4_s0_newshadow", 2'd0, 4'b1110, 4'h6, 1'b1);
        cyc(4); chk("f4_s1", 2'd1, 4'b1101, 4'h7, 1'b0);

        // leading-zero blanking on 0050
        load = 1'b1; value_in = 16'h0050;
        cyc(1); load = 1'b0;
        cyc(3); chk("f4_s2", 2'd2, 4'b1011, 4'h8, 1'b0);
        cyc(4); chk("f4_s3", 2'd3, 4'b0111, 4'h9, 1'b0);
        blank_lz = 1'b1;
        cyc(4); chk("lz_s0", 2'd0, 4'b1110, 4'h0, 1'b1);
        cyc(4); chk("lz_s1", 2'd1, 4'b1101, 4'h5, 1'b0);
        cyc(4); chk("lz_s2", 2'd2, 4'b1111, 4'hF, 1'b0);
        cyc(4); chk("lz_s3", 2'd3, 4'b1111, 4'hF, 1'b0);
        blank_lz = 1'b0;
        cyc(4); chk("nolz_s0", 2'd0, 4'b1110, 4'h0, 1'b1);
        load = 1'b1; value_in = 16'h0000;
        cyc(1); load = 1'b0;
        cyc(3); chk("nolz_s1", 2'd1, 4'b1101, 4'h5, 1'b0);
        cyc(4); chk("nolz_s2", 2'd2, 4'b1011, 4'h0, 1'b0);
        cyc(4); chk("nolz_s3", 2'd3, 4'b0111, 4'h0, 1'b0);
        blank_lz = 1'b1;

        // all-zero value with blanking: only digit 0 lit
        cyc(4); chk("zero_s0", 2'd0, 4'b1110, 4'h0, 1'b1);
        load = 1'b1; value_in = 16'h1A23;
        cyc(1); load = 1'b0;
        cyc(3); chk("zero_s1", 2'd1, 4'b1111, 4'hF, 1'b0);
        cyc(4); chk("zero_s2", 2'd2, 4'b1111, 4'hF, 1'b0);
        cyc(4); chk("zero_s3", 2'd3, 4'b1111, 4'hF, 1'b0);

        // invalid nibble in digit 2
        cyc(4); chk("inv_s0", 2'd0, 4'b1110, 4'h3, 1'b1);
        cyc(4); chk("inv_s1", 2'd1, 4'b1101, 4'h2, 1'b0);
        cyc(4); chk("inv_s2", 2'd2, 4'b1111, 4'hF, 1'b0);
        cyc(4); chk("inv_s3", 2'd3, 4'b0111, 4'h1, 1'b0);
        cyc(4); chk("inv2_s0", 2'd0, 4'b1110, 4'h3, 1'b1);

        // reset mid-frame with a pending load
        cyc(4); chk("pre_rst_s1", 2'd1, 4'b1101, 4'h2, 1'b0);
        load = 1'b1; value_in = 16'h9999;
        cyc(1); load = 1'b0;
        rst = 1'b1;
        cyc(1); chk("midrst", 2'd3, 4'b1111, 4'hF, 1'b0);
        rst = 1'b0;
        cyc(3); chk("midrst_dark", 2'd3, 4'b1111, 4'hF, 1'b0);
        cyc(1); chk("midrst_f0_s0", 2'd0, 4'b1110, 4'h0, 1'b1);
        cyc(4); chk("midrst_f0_s1", 2'd1, 4'b1111, 4'hF, 1'b0);
        cyc(12); chk("midrst_f1_s0", 2'd0, 4'b1110, 4'h0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
